// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared types and constants for the mcpu_core multi-cycle CPU
// Holds the FSM state enum, the decoded opcode class, opcode bit patterns,
// instruction field positions and the opcode decode helper.
package mcpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    typedef enum logic [2:0] {
        OPC_ADD,
        OPC_SUB,
        OPC_LDUR,
        OPC_STUR,
        OPC_B,
        OPC_CBZ,
        OPC_ILL
    } opc_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    // Field positions (LSB) within the 32-bit instruction word.
    localparam int REG_W     = 5;
    localparam int RD_LSB    = 0;   // Rd, also Rt for LDUR/STUR/CBZ
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;
    localparam int IMM9_LSB  = 12;
    localparam int IMM19_LSB = 5;
    localparam int IMM26_LSB = 0;

    function automatic opc_e decode_op(input logic [31:0] ir);
        if (ir[31:21] == OP_ADD)       return OPC_ADD;
        else if (ir[31:21] == OP_SUB)  return OPC_SUB;
        else if (ir[31:21] == OP_LDUR) return OPC_LDUR;
        else if (ir[31:21] == OP_STUR) return OPC_STUR;
        else if (ir[31:26] == OP_B)    return OPC_B;
        else if (ir[31:24] == OP_CBZ)  return OPC_CBZ;
        else                           return OPC_ILL;
    endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// rtl/mcpu_regfile.sv - 32 x XLEN register file, two registered read ports, one write port
// Ports: clk; raddr1_i/raddr2_i read addresses; rdata1_o/rdata2_o registered read data
// (X31 reads as zero); we_i/waddr_i/wdata_i write port (writes to X31 discarded).
module mcpu_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != 5'd31)) begin
            regs_q[waddr_i] <= wdata_i;
        end
        rdata1_o <= (raddr1_i == 5'd31) ? '0 : regs_q[raddr1_i];
        rdata2_o <= (raddr2_i == 5'd31) ? '0 : regs_q[raddr2_i];
    end

endmodule

// File: rtl/mcpu_core.sv
// rtl/mcpu_core.sv - multi-cycle CPU (IDLE/FETCH/DECODE/EXEC/MEM/WB) with code and data memories
// Ports: clk; resetn async active-low; run execute enable; imem_we/imem_waddr/imem_wdata
// code-memory load port (IDLE only); pc in-flight word address; led = pc[1]; retired
// one-cycle pulse per completed instruction; illegal sticky undecodable flag;
// debug_port1/2/3 = pc[7:0], rs1 data[7:0], instruction[7:0] when MCPU_DEBUG_EN is
// defined, otherwise tied to zero.
module mcpu_core
    import mcpu_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int CODE_DEPTH = 512,
    parameter  int DATA_DEPTH = 512,
    localparam int PCW        = $clog2(CODE_DEPTH),
    localparam int DAW        = $clog2(DATA_DEPTH)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           run,
    input  logic           imem_we,
    input  logic [PCW-1:0] imem_waddr,
    input  logic [31:0]    imem_wdata,
    output logic [PCW-1:0] pc,
    output logic           led,
    output logic           retired,
    output logic           illegal,
    output logic [7:0]     debug_port1,
    output logic [7:0]     debug_port2,
    output logic [7:0]     debug_port3
);

    state_e          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic            illegal_q, illegal_d;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] wb_data_q;
    logic [DAW-1:0]  addr_q;

    logic [31:0]     code_q [CODE_DEPTH];
    logic [XLEN-1:0] dmem_q [DATA_DEPTH];

    opc_e            opc;
    logic [4:0]      raddr2;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            rf_we;
    logic            dmem_we;
    logic [XLEN-1:0] imm9_x;
    logic [XLEN-1:0] alu_res;
    logic [DAW-1:0]  ea;
    logic [PCW-1:0]  pc_inc, pc_b, pc_cbz;
    logic            fin;
    logic [PCW-1:0]  npc;

    assign opc = decode_op(ir_q);

    // STUR and CBZ source their second operand from the Rt field.
    assign raddr2 = (opc == OPC_STUR || opc == OPC_CBZ) ? ir_q[RD_LSB +: REG_W]
                                                        : ir_q[RM_LSB +: REG_W];

    mcpu_regfile #(.XLEN(XLEN)) u_rf (
        .clk      (clk),
        .raddr1_i (ir_q[RN_LSB +: REG_W]),
        .raddr2_i (raddr2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .we_i     (rf_we),
        .waddr_i  (ir_q[RD_LSB +: REG_W]),
        .wdata_i  (wb_data_q)
    );

    assign imm9_x  = {{(XLEN-9){ir_q[IMM9_LSB+8]}}, ir_q[IMM9_LSB +: 9]};
    assign alu_res = (opc == OPC_SUB) ? (rdata1 - rdata2) : (rdata1 + rdata2);
    assign ea      = DAW'(rdata1 + imm9_x);

    // Branch offsets only matter modulo CODE_DEPTH, so truncating before the add is exact.
    assign pc_inc = pc_q + PCW'(1);
    assign pc_b   = pc_q + PCW'({{6{ir_q[IMM26_LSB+25]}}, ir_q[IMM26_LSB +: 26]});
    assign pc_cbz = pc_q + PCW'({{13{ir_q[IMM19_LSB+18]}}, ir_q[IMM19_LSB +: 19]});

    assign rf_we   = (state_q == ST_WB);
    assign dmem_we = (state_q == ST_MEM) && (opc == OPC_STUR);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        fin       = 1'b0;
        npc       = pc_inc;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (opc)
                    OPC_ADD, OPC_SUB:   state_d = ST_WB;
                    OPC_LDUR, OPC_STUR: state_d = ST_MEM;
                    OPC_B: begin
                        fin = 1'b1;
                        npc = pc_b;
                    end
                    OPC_CBZ: begin
                        fin = 1'b1;
                        npc = (rdata2 == '0) ? pc_cbz : pc_inc;
                    end
                    default: begin
                        fin       = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (opc == OPC_LDUR) state_d = ST_WB;
                else                 fin = 1'b1;
            end
            ST_WB:   fin = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        // Final cycle of every instruction: commit pc and choose between FETCH and IDLE.
        if (fin) begin
            pc_d    = npc;
            state_d = run ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath registers and memories are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_FETCH) ir_q <= code_q[pc_q];
        if (state_q == ST_EXEC) begin
            wb_data_q <= alu_res;
            addr_q    <= ea;
        end
        if (state_q == ST_MEM && opc == OPC_LDUR) wb_data_q <= dmem_q[addr_q];
    end

    always_ff @(posedge clk) begin
        if (imem_we && state_q == ST_IDLE) code_q[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (dmem_we) dmem_q[addr_q] <= rdata2;
    end

    assign pc      = pc_q;
    assign led     = pc_q[1];
    assign retired = fin;
    assign illegal = illegal_q;

`ifdef MCPU_DEBUG_EN
    assign debug_port1 = 8'(pc_q);
    assign debug_port2 = rdata1[7:0];
    assign debug_port3 = ir_q[7:0];
`else
    assign debug_port1 = 8'd0;
    assign debug_port2 = 8'd0;
    assign debug_port3 = 8'd0;
`endif

endmodule

// File: tb/tb_mcpu_core.sv
// tb/tb_mcpu_core.sv - directed self-checking testbench for mcpu_core
module tb_mcpu_core;
    import mcpu_pkg::*;

    localparam int PCW = 9;

    logic           clk = 1'b0;
    logic           resetn;
    logic           run;
    logic           imem_we;
    logic [PCW-1:0] imem_waddr;
    logic [31:0]    imem_wdata;
    logic [PCW-1:0] pc;
    logic           led, retired, illegal;
    logic [7:0]     debug_port1, debug_port2, debug_port3;

    int             total = 0;
    int             bad = 0;
    int             cyc;
    logic [PCW-1:0] pcs;

    always #5 clk = ~clk;

    mcpu_core #(.XLEN(32), .CODE_DEPTH(512), .DATA_DEPTH(512)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .pc          (pc),
        .led         (led),
        .retired     (retired),
        .illegal     (illegal),
        .debug_port1 (debug_port1),
        .debug_port2 (debug_port2),
        .debug_port3 (debug_port3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'b000000, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    function automatic logic [31:0] enc_cbz(input logic [18:0] imm, input logic [4:0] rt);
        return {8'b10110100, imm, rt};
    endfunction

    task automatic do_reset();
        run    = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input logic [PCW-1:0] a, input logic [31:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        @(negedge clk);
        imem_we    = 1'b0;
    endtask

    // Counts cycles up to and including the one with retired high; returns the in-flight pc.
    task automatic wait_retire(input int drop_at, output int c, output logic [PCW-1:0] p);
        bit done;
        done = 1'b0;
        c    = 0;
        p    = '0;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
            if (c == drop_at) run = 1'b0;
            if (retired) begin
                done = 1'b1;
                p    = pc;
            end
        end
        if (!done) c = 99;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; run = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_dmem_we", 64'(dut.dmem_we), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // ADD / SUB / B 0 loop, with a code write attempted while running
        load(9'd0, enc_r(11'b10001011000, 5'd31, 5'd31, 5'd1));
        load(9'd1, enc_r(11'b11001011000, 5'd1, 5'd1, 5'd2));
        load(9'd2, enc_b(26'h3FFFFFE));
        dut.u_rf.regs_q[1] <= 32'h55;
        dut.u_rf.regs_q[2] <= 32'h66;
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        check("add_cycles", 64'(cyc), 64'd4);
        check("add_pc", 64'(pcs), 64'd0);
        imem_we = 1'b1; imem_waddr = 9'd2; imem_wdata = 32'hFFFFFFFF;
        wait_retire(0, cyc, pcs);
        imem_we = 1'b0;
        check("sub_cycles", 64'(cyc), 64'd4);
        check("sub_pc", 64'(pcs), 64'd1);
        wait_retire(0, cyc, pcs);
        run = 1'b0;
        check("b_cycles", 64'(cyc), 64'd3);
        check("b_pc", 64'(pcs), 64'd2);
        @(negedge clk);
        check("loop_pc", 64'(pc), 64'd0);
        check("loop_idle", 64'(dut.state_q), 64'(ST_IDLE));
        check("add_x1", 64'(dut.u_rf.regs_q[1]), 64'd0);
        check("sub_x2", 64'(dut.u_rf.regs_q[2]), 64'd0);
        check("busy_write_ignored", 64'(illegal), 64'd0);

        // STUR / LDUR round trip; run drops during LDUR
        do_reset();
        load(9'd0, enc_d(11'b11111000000, 9'd7, 5'd31, 5'd3));
        load(9'd1, enc_d(11'b11111000010, 9'd7, 5'd31, 5'd4));
        dut.u_rf.regs_q[3] <= 32'd5;
        dut.u_rf.regs_q[4] <= 32'hAA;
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        check("stur_cycles", 64'(cyc), 64'd4);
        wait_retire(2, cyc, pcs);
        check("ldur_cycles", 64'(cyc), 64'd5);
        check("ldur_pc", 64'(pcs), 64'd1);
        @(negedge clk);
        check("ldur_x4", 64'(dut.u_rf.regs_q[4]), 64'd5);
        check("stur_mem7", 64'(dut.dmem_q[7]), 64'd5);
        repeat (3) @(negedge clk);
        check("run0_idle", 64'(dut.state_q), 64'(ST_IDLE));
        check("run0_pc", 64'(pc), 64'd2);

        // B -1 wraps to the top, sequential fetch from the top wraps to 0
        do_reset();
        load(9'd0, enc_b(26'h3FFFFFF));
        load(9'd511, enc_r(11'b10001011000, 5'd31, 5'd31, 5'd7));
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        check("bneg_cycles", 64'(cyc), 64'd3);
        wait_retire(0, cyc, pcs);
        run = 1'b0;
        check("top_pc", 64'(pcs), 64'd511);
`ifdef MCPU_DEBUG_EN
        check("debug_port1", 64'(debug_port1), 64'hFF);
`else
        check("debug_port1", 64'(debug_port1), 64'h00);
`endif
        @(negedge clk);
        check("wrap_pc", 64'(pc), 64'd0);

        // CBZ X5,#+3 at pc 4, taken and not taken
        do_reset();
        load(9'd0, enc_b(26'd4));
        load(9'd4, enc_cbz(19'd3, 5'd5));
        dut.u_rf.regs_q[5] <= 32'd0;
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        wait_retire(0, cyc, pcs);
        run = 1'b0;
        check("cbz_cycles", 64'(cyc), 64'd3);
        check("cbz_at_pc", 64'(pcs), 64'd4);
        @(negedge clk);
        check("cbz_taken_pc", 64'(pc), 64'd7);
        check("cbz_taken_led", 64'(led), 64'd1);
        do_reset();
        dut.u_rf.regs_q[5] <= 32'd1;
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        wait_retire(0, cyc, pcs);
        run = 1'b0;
        @(negedge clk);
        check("cbz_fall_pc", 64'(pc), 64'd5);
        check("cbz_fall_led", 64'(led), 64'd0);

        // Undecodable instructions
        do_reset();
        load(9'd0, 32'hFFFFFFFF);
        load(9'd1, 32'hFFFFFFE6);
        dut.u_rf.regs_q[6] <= 32'h1234;
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        check("ill_cycles", 64'(cyc), 64'd3);
        wait_retire(0, cyc, pcs);
        run = 1'b0;
        check("ill_second_pc", 64'(pcs), 64'd1);
        check("ill_set", 64'(illegal), 64'd1);
        @(negedge clk);
        check("ill_pc", 64'(pc), 64'd2);
        check("ill_x6", 64'(dut.u_rf.regs_q[6]), 64'h1234);
        repeat (3) @(negedge clk);
        check("ill_sticky", 64'(illegal), 64'd1);

        // Reset during WB of ADD X6
        do_reset();
        check("ill_cleared", 64'(illegal), 64'd0);
        load(9'd0, enc_r(11'b10001011000, 5'd31, 5'd31, 5'd6));
        dut.u_rf.regs_q[6] <= 32'h77;
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        check("wb_state", 64'(dut.state_q), 64'(ST_WB));
        resetn = 1'b0;
        run    = 1'b0;
        @(negedge clk);
        check("rst_wb_x6", 64'(dut.u_rf.regs_q[6]), 64'h77);
        check("rst_wb_pc", 64'(pc), 64'd0);
        check("rst_wb_idle", 64'(dut.state_q), 64'(ST_IDLE));
        resetn = 1'b1;
        @(negedge clk);
        run = 1'b1;
        wait_retire(0, cyc, pcs);
        run = 1'b0;
        check("rerun_cycles", 64'(cyc), 64'd4);
        check("rerun_pc", 64'(pcs), 64'd0);
        @(negedge clk);
        check("rerun_x6", 64'(dut.u_rf.regs_q[6]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcpu_core.md
MCPU_CORE -- requirements
Module: mcpu_core

Interface
REQ-001 Parameter XLEN, default 32: register and data-memory word width, 16..64.
REQ-002 Parameter CODE_DEPTH, default 512: instruction words, power of two; PCW = $clog2(CODE_DEPTH).
REQ-003 Parameter DATA_DEPTH, default 512: data words, power of two; DAW = $clog2(DATA_DEPTH).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  1 = execute; 0 = finish current instruction, then stay in IDLE.
REQ-007 imem_we / imem_waddr / imem_wdata  in  1 / PCW / 32  code-memory write port; honoured only in IDLE.
REQ-008 pc  out  PCW  word address of the instruction in flight.
REQ-009 led  out  1  pc[1].
REQ-010 retired  out  1  one-cycle pulse per completed instruction.
REQ-011 illegal  out  1  sticky, set by an undecodable instruction.
REQ-012 debug_port1/2/3  out  8 each  pc[7:0], rs1 read data[7:0], fetched instruction[7:0].

Function
REQ-013 Multi-cycle FSM, states IDLE, FETCH, DECODE, EXEC, MEM, WB; IDLE->FETCH when run=1.
REQ-014 FETCH: synchronous code read at pc; instruction registered, valid in DECODE.
REQ-015 DECODE: registered reads of Rn (bits 9:5) and Rm/Rt (bits 20:16 for R-type, 4:0 for STUR/CBZ); valid in EXEC.
REQ-016 Opcodes: ADD 10001011000, SUB 11001011000, LDUR 11111000010, STUR 11111000000, B 000101, CBZ 10110100.
REQ-017 ADD/SUB: EXEC computes Rn +/- Rm modulo 2^XLEN; WB writes Rd (4:0); 4 cycles.
REQ-018 LDUR/STUR: data address = (Rn + sign-extended imm9 [20:12]) truncated to DAW bits; STUR writes in MEM (4 cycles); LDUR reads in MEM, writes Rt in WB (5 cycles).
REQ-019 B: pc <= pc + sign-extended imm26, modulo CODE_DEPTH; 3 cycles.
REQ-020 CBZ: if Rt == 0, pc <= pc + sign-extended imm19 [23:5], else pc + 1; modulo CODE_DEPTH; 3 cycles.
REQ-021 All other instructions: illegal <= 1, treated as NOP (pc + 1), 3 cycles.
REQ-022 Register X31 reads 0; writes to X31 discarded.
REQ-023 retired pulses in the final cycle of each instruction, coincident with the pc update.
REQ-024 After the final cycle, next state is FETCH if run=1, else IDLE; run deasserting mid-instruction never aborts it.
REQ-025 pc + 1 at CODE_DEPTH-1 wraps to 0.
REQ-026 imem_we outside IDLE is ignored.

Reset
REQ-027 resetn low: state IDLE, pc 0, retired 0, illegal 0, data-memory write enable 0; register file and memories not cleared.
REQ-028 Reset mid-instruction abandons it with no register or memory write; first fetch after release is from address 0.

Configuration
REQ-029 Macro MCPU_DEBUG_EN defined: debug_port1/2/3 driven per REQ-012.
REQ-030 Macro MCPU_DEBUG_EN undefined: the debug ports exist but are tied to 0; led is unaffected.

Structure
REQ-031 Package mcpu_pkg holds the state enum, opcode constants, and field-position constants.
REQ-032 Sub-module mcpu_regfile: 32 x XLEN, two registered read ports, one write port, X31 read as zero.
REQ-033 Code and data memories are inferred inside mcpu_core as synchronous-read arrays.

Verification
REQ-034 Load ADD X1,X31,X31, then SUB X2,X1,X1, then B 0; run=1 -> retired every 4/4/3 cycles; pc sequence 0,1,2,0.
REQ-035 Preload X3=5, STUR X3,[X31,#7], LDUR X4,[X31,#7] -> X4=5; data memory word 7 = 5; LDUR takes 5 cycles.
REQ-036 B with imm26 = -1 at pc 0 -> pc = CODE_DEPTH-1; sequential fetch from CODE_DEPTH-1 -> pc = 0.
REQ-037 CBZ X5,#+3 at pc 4: X5=0 -> pc=7; X5=1 -> pc=5.
REQ-038 Instruction 0xFFFFFFFF -> illegal=1 and stays 1; pc advances by 1; no register changes.
REQ-039 Assert resetn low during the WB of an ADD to X6 -> X6 unchanged, pc=0, state IDLE; run=0 mid-instruction -> the instruction completes, then the core holds in IDLE.
